// File: rtl/keypad_scan_if.sv
// CPU-side event port of the keypad scanner: press code, valid/ack handshake, status flags.
// Pure wiring bundle, no storage and no added latency.
// The consumer stalls delivery by holding KeyAck low; the scanner then keeps Key frozen.
interface keypad_scan_if;
   logic [3:0] Key;       // code of the last accepted press
   logic       KeyValid;  // press event pending
   logic       KeyAck;    // consumer accepts the pending event
   logic       Pressed;   // debounced "any key down" level
   logic       Overrun;   // sticky: a press event was lost

   // Scanner side drives the event and status lines.
   modport master (
      output Key,
      output KeyValid,
      output Pressed,
      output Overrun,
      input  KeyAck
   );

   // CPU side consumes events and returns the acknowledge.
   modport slave (
      input  Key,
      input  KeyValid,
      input  Pressed,
      input  Overrun,
      output KeyAck
   );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one column at a time, debounces whole scans, reports new presses.
// Press visible on KeyValid within (DEBOUNCE+1)*4*DWELL+1 clocks; full scan takes 4*DWELL clocks.
// Events are held until KeyAck; an event arriving while one is pending without ack is dropped and flagged.
module keypad_scan #(
   parameter int DWELL    = 4,   // clocks each column is driven, 3 or more
   parameter int DEBOUNCE = 2    // identical full scans needed to accept a new state, 1..15
) (
   input  logic        CLK,
   input  logic        RST,      // asynchronous, active low
   input  logic [3:0]  H,        // row sense lines, asynchronous to CLK
   output logic [3:0]  V,        // one-hot column drive
   keypad_scan_if.master cpu
);

   localparam int                DCNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(DWELL - 1);
   localparam logic [3:0]        STABLE_MAX = 4'(DEBOUNCE);

   // Classification of one complete scan (and of the debounced state).
   typedef enum logic [1:0] {
      CLS_NONE   = 2'd0,
      CLS_SINGLE = 2'd1,
      CLS_MULTI  = 2'd2
   } cls_t;

   // Code is only meaningful for SINGLE; kept at 0 otherwise so that
   // whole-struct equality compares classes correctly.
   typedef struct packed {
      cls_t       cls;
      logic [3:0] code;
   } res_t;

   localparam res_t RES_NONE = '{cls: CLS_NONE, code: 4'd0};

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [1:0]        col;        // column currently driven
   logic [DCNT_W-1:0] dcnt;       // dwell position inside the column
   logic [3:0]        h_meta;     // first synchronizer stage
   logic [3:0]        h_sync;     // second synchronizer stage, safe to use
   logic [15:0]       scan_vec;   // row samples of the scan in progress
   res_t              cand;       // most recent scan result
   logic [3:0]        stable;     // consecutive scans equal to cand, saturating
   res_t              deb;        // debounced keypad state
   logic [3:0]        key_q;
   logic              key_vld;
   logic              overrun;

   // ------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------
   logic              col_last;   // last dwell cycle of the current column
   logic              scan_end;   // last dwell cycle of column 3
   logic [15:0]       full_vec;   // complete scan including the column-3 sample
   logic [1:0]        ones;       // set bits in full_vec, saturating at 2
   logic [3:0]        hit_idx;    // index of a set bit (valid when ones == 1)
   res_t              scan_res;
   res_t              cand_nxt;
   logic [3:0]        stable_nxt;
   res_t              deb_nxt;
   logic              press_evt;  // debounced state moves into SINGLE(k)
   logic [3:0]        key_nxt;
   logic              key_vld_nxt;
   logic              overrun_nxt;

   assign col_last = (dcnt == DCNT_LAST);
   assign scan_end = col_last && (col == 2'd3);

   // Column 3 is sampled on the same cycle the scan is classified, so its
   // rows come straight from the synchronizer rather than from scan_vec.
   assign full_vec = {h_sync, scan_vec[11:0]};

   // Column/dwell counters; V rotates so it always matches col.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         col  <= 2'd0;
         dcnt <= '0;
         V    <= 4'b0001;
      end else if (col_last) begin
         col  <= col + 2'd1;
         dcnt <= '0;
         V    <= {V[2:0], V[3]};
      end else begin
         dcnt <= dcnt + DCNT_W'(1);
      end
   end

   // Two-flop synchronizer for the asynchronous row lines.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         h_meta <= 4'd0;
         h_sync <= 4'd0;
      end else begin
         h_meta <= H;
         h_sync <= h_meta;
      end
   end

   // Capture the settled rows of the driven column at the end of its dwell.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         scan_vec <= 16'd0;
      end else if (col_last) begin
         scan_vec[{col, 2'b00} +: 4] <= h_sync;
      end
   end

   // Classify the completed scan as NONE, SINGLE(k) or MULTI.
   always_comb begin
      ones     = 2'd0;
      hit_idx  = 4'd0;
      scan_res = RES_NONE;
      for (int i = 0; i < 16; i++) begin
         if (full_vec[i]) begin
            hit_idx = 4'(i);
            if (ones != 2'd2) begin
               ones = ones + 2'd1;
            end
         end
      end
      if (ones == 2'd1) begin
         scan_res = '{cls: CLS_SINGLE, code: hit_idx};
      end else if (ones == 2'd2) begin
         scan_res = '{cls: CLS_MULTI, code: 4'd0};
      end
   end

   // Debounce: count repeated scan results, adopt the candidate once stable.
   always_comb begin
      cand_nxt   = cand;
      stable_nxt = stable;
      deb_nxt    = deb;
      press_evt  = 1'b0;
      if (scan_end) begin
         if (scan_res == cand) begin
            if (stable < STABLE_MAX) begin
               stable_nxt = stable + 4'd1;
            end
         end else begin
            cand_nxt   = scan_res;
            stable_nxt = 4'd1;
         end
         // The debounced state follows on the very scan that makes the
         // candidate stable; only entry into SINGLE(k) is a press.
         if ((stable_nxt == STABLE_MAX) && (cand_nxt != deb)) begin
            deb_nxt   = cand_nxt;
            press_evt = (cand_nxt.cls == CLS_SINGLE);
         end
      end
   end

   // Event handshake: load when free or acked this cycle, else flag overrun.
   always_comb begin
      key_nxt     = key_q;
      key_vld_nxt = key_vld;
      overrun_nxt = overrun;
      if (press_evt) begin
         if (!key_vld || cpu.KeyAck) begin
            key_nxt     = cand_nxt.code;
            key_vld_nxt = 1'b1;
         end else begin
            overrun_nxt = 1'b1;
         end
      end else if (key_vld && cpu.KeyAck) begin
         key_vld_nxt = 1'b0;
      end
   end

   // Debounce and handshake state registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cand    <= RES_NONE;
         stable  <= 4'd0;
         deb     <= RES_NONE;
         key_q   <= 4'd0;
         key_vld <= 1'b0;
         overrun <= 1'b0;
      end else begin
         cand    <= cand_nxt;
         stable  <= stable_nxt;
         deb     <= deb_nxt;
         key_q   <= key_nxt;
         key_vld <= key_vld_nxt;
         overrun <= overrun_nxt;
      end
   end

   assign cpu.Key      = key_q;
   assign cpu.KeyValid = key_vld;
   assign cpu.Pressed  = (deb.cls != CLS_NONE);
   assign cpu.Overrun  = overrun;

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Synchronous 4x4 matrix-keypad scanner: the initiator end of the keypad matrix on `H`/`V`. It drives one column line (`V`) high at a time, samples the pulled-down row lines (`H`), and debounces over whole scans. Each new single-key press is reported as a 4-bit key code through a valid/ack handshake to the CPU I/O logic inside `Hardware`. Key index = 4*column + row, so the switch joining `H[r]` to `V[c]` is key `4c+r`.

## Interface
Parameters:
- `DWELL`, default 4: clocks each column is driven; legal values are 3 and up.
- `DEBOUNCE`, default 2: consecutive identical full-scan results needed to accept a new state; legal values are 1 to 15.

Ports:
- `CLK`  in  1  system clock.
- `RST`  in  1  reset. One clock; reset is asynchronous and active-low.
- `H`  in  4  row sense lines, externally pulled down; high means a closed switch on the driven column.
- `V`  out  4  column drive, one-hot, active high.
- `Key`  out  4  code of the last accepted press.
- `KeyValid`  out  1  press event pending.
- `KeyAck`  in  1  consumer accepts the pending event.
- `Pressed`  out  1  debounced "any key down" level.
- `Overrun`  out  1  sticky flag: a press event was lost.

## Operation
- **Column counter:** `col` (2 bits) and dwell counter `dcnt` (0..DWELL-1).
  - `V = 1 << col`, registered.
  - When `dcnt` reaches DWELL-1, `col` increments and wraps 3 to 0.
  - One full scan = 4*DWELL cycles.
- **Row input:** `H` is asynchronous. It passes through a 2-flop synchronizer before any use.
- **Row sampling:** the synchronized `H` is sampled at `dcnt == DWELL-1` of each column and accumulated into a 16-bit scan vector at bits `4*col +: 4`.
- **Scan classification,** evaluated at the last dwell cycle of column 3:
  - NONE: vector is 0.
  - SINGLE(k): exactly one bit set, at index k.
  - MULTI: more than one bit set.
- **Debounce:**
  - A 4-bit `stable` count and a `cand` register hold the previous scan result.
  - If the result equals `cand`: `stable` increments, saturating at DEBOUNCE.
  - Otherwise: `cand` takes the result and `stable` is set to 1.
  - When `stable` reaches DEBOUNCE and `cand` differs from the debounced state `deb`, `deb` takes `cand` on the same cycle.
- **Debounced states:** NONE, SINGLE(k), MULTI. MULTI models ghosting/rollover and never produces a code.
- **Events:** a transition of `deb` into SINGLE(k) generates a press event.
  - This applies from NONE, from MULTI, or from SINGLE(j) with j≠k.
  - A transition to NONE or to MULTI generates no event.
- **`Pressed`:** equals 1 when `deb` is not NONE.
- **Handshake:**
  - On an event with `KeyValid` = 0: `Key` takes k and `KeyValid` is set to 1 on the next edge.
  - `KeyValid` stays 1 and `Key` stays frozen until a cycle with `KeyAck` = 1. `KeyValid` then clears on that edge.
  - `KeyAck` while `KeyValid` = 0 is ignored.
- **Overrun:**
  - An event arriving while `KeyValid` = 1 and `KeyAck` = 0 is dropped. `Overrun` is set, and `Key` is unchanged.
  - If `KeyAck` = 1 in the same cycle as an event, the new event is loaded. `KeyValid` stays 1, `Key` takes k, and there is no overrun.
  - `Overrun` clears only on reset.

## Timing
- **Reset values (asynchronous, while `RST` = 0):**
  - `V` = 4'b0001, `col` = 0, `dcnt` = 0.
  - Synchronizer and scan vector = 0.
  - `cand` = NONE, `stable` = 0, `deb` = NONE.
  - `Key` = 0, `KeyValid` = 0, `Pressed` = 0, `Overrun` = 0.
- **First scan:** starts on the first rising edge after `RST` deasserts.
- **Settling:** `H` for column c is sampled 2 or more cycles after `V` switched to c, because the synchronizer adds 2 cycles. This is why DWELL ≥ 3 is required.
- **Press latency:** press held from cycle t; `KeyValid` rises no later than t + (DEBOUNCE+1)*4*DWELL + 1. With defaults, that is ≤ 49 cycles.
- **Release latency:** `Pressed` falls within the same bound after release.
- **Minimum press duration** guaranteed to be detected: (DEBOUNCE+1)*4*DWELL cycles.
- **Reset mid-scan or mid-handshake:** all state returns to the reset values and any pending event is discarded.

## Test plan
- **Single press:**
  - Stimulus: reset low for 2 cycles, then close key 3 (`H[3]`–`V[0]`) from cycle 4 for 48 cycles. Hold `KeyAck` = 0.
  - Required: `V` cycles 0001→0010→0100→1000 every 4 cycles. `KeyValid` = 1 with `Key` = 3 by cycle 52. `Pressed` = 1, then returns to 0 within 49 cycles of release. `Overrun` = 0.
- **Ack:**
  - Stimulus: as above, then pulse `KeyAck` for 1 cycle.
  - Required: `KeyValid` falls on the next edge. The key is still held, and no second event occurs.
- **Bounce:**
  - Stimulus: key 9 (`H[1]`–`V[2]`) toggles every 5 cycles for 60 cycles, then is held for 64 cycles.
  - Required: exactly one event, `Key` = 9, and no event during the toggling phase.
- **Ghost:**
  - Stimulus: keys 0 and 5 held together for 64 cycles, then released.
  - Required: `Pressed` = 1 and `KeyValid` stays 0.
  - Follow-on: key 0 is then released while key 5 is kept held. Required: event with `Key` = 5.
- **Overrun:**
  - Stimulus: press and release key 2, then press key 14, never acking.
  - Required: `Key` = 2, `KeyValid` = 1, `Overrun` = 1.
- **Reset during hold:**
  - Stimulus: assert `RST` = 0 mid-column while key 7 is held and `KeyValid` = 1.
  - Required: all outputs take their reset values immediately (asynchronously). After reset releases, key 7 is re-detected within 49 cycles.
